// File: rtl/i2c_reg_target.sv
// I2C register target: decodes SCL/SDA traffic into register write strobes
// and serves register reads from downstream combinational read data.
`timescale 1ns/1ps
module i2c_reg_target #(
  parameter logic [6:0] DEV_ADDR = 7'h2A,
  parameter int         REG_AW   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              reg_wr_en,
  output logic [REG_AW-1:0] reg_wr_addr,
  output logic [7:0]        reg_wr_data,
  output logic [REG_AW-1:0] reg_rd_addr,
  input  logic [7:0]        reg_rd_data,
  output logic              busy
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_REG, ST_REG_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_WAIT_STOP
  } state_t;

  state_t state_q, state_d;

  // [0],[1] synchronize, [2] is history; reset high so the idle bus shows no edges
  logic [2:0] scl_q, sda_q;
  logic scl_s, scl_h, sda_s, sda_h;
  logic scl_rise, scl_fall, start_det, stop_det;

  // two-flop synchronizer plus history flop per pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  assign scl_s     = scl_q[1];
  assign scl_h     = scl_q[2];
  assign sda_s     = sda_q[1];
  assign sda_h     = sda_q[2];
  assign scl_rise  = scl_s & ~scl_h;
  assign scl_fall  = ~scl_s & scl_h;
  assign start_det = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;

  // bit counter counts rises; 8 means a full byte is in and the ACK slot is next
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        sh_q, sh_d;
  logic [REG_AW-1:0] ptr_q, ptr_d;
  logic              inc_q, inc_d;
  logic              oe_d, wen_d, busy_d;
  logic [REG_AW-1:0] wa_d;
  logic [7:0]        wd_d;
  logic              byte_done, addr_hit;

  assign byte_done   = (cnt_q == 4'd8);
  assign addr_hit    = (sh_q[7:1] == DEV_ADDR);
  assign reg_rd_addr = ptr_q;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // next state: bus conditions override bit handling in every state
  always_comb begin
    state_d = state_q;
    if (stop_det)       state_d = ST_IDLE;
    else if (start_det) state_d = ST_ADDR;
    else begin
      case (state_q)
        ST_ADDR:      if (scl_fall && byte_done) state_d = addr_hit ? ST_ADDR_ACK : ST_WAIT_STOP;
        ST_ADDR_ACK:  if (scl_fall) state_d = sh_q[0] ? ST_RDATA : ST_REG;
        ST_REG:       if (scl_fall && byte_done) state_d = ST_REG_ACK;
        ST_REG_ACK:   if (scl_fall) state_d = ST_WDATA;
        ST_WDATA:     if (scl_fall && byte_done) state_d = ST_WDATA_ACK;
        ST_WDATA_ACK: if (scl_fall) state_d = ST_WDATA;
        ST_RDATA:     if (scl_fall && byte_done) state_d = ST_RDATA_ACK;
        ST_RDATA_ACK: begin
          // controller NACK ends the read; ACK continues at the next fall
          if (scl_rise && sda_s) state_d = ST_WAIT_STOP;
          else if (scl_fall)     state_d = ST_RDATA;
        end
        default: ;
      endcase
    end
  end

  // datapath and outputs: SDA drive only moves on SCL falls (or bus conditions)
  always_comb begin
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    ptr_d  = ptr_q;
    inc_d  = 1'b0;
    oe_d   = sda_oe;
    wen_d  = 1'b0;
    wa_d   = reg_wr_addr;
    wd_d   = reg_wr_data;
    busy_d = busy;
    // pointer steps the cycle after a write strobe
    if (inc_q) ptr_d = ptr_q + REG_AW'(1);
    if (stop_det) begin
      oe_d   = 1'b0;
      busy_d = 1'b0;
      cnt_d  = 4'd0;
    end else if (start_det) begin
      oe_d  = 1'b0;
      cnt_d = 4'd0;
    end else if (scl_rise) begin
      case (state_q)
        ST_ADDR, ST_REG, ST_WDATA:
          if (!byte_done) begin
            sh_d  = {sh_q[6:0], sda_s};
            cnt_d = cnt_q + 4'd1;
          end
        ST_RDATA:     if (!byte_done) cnt_d = cnt_q + 4'd1;
        // advance before the next fall so reg_rd_data is ready to latch
        ST_RDATA_ACK: if (!sda_s) ptr_d = ptr_q + REG_AW'(1);
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        ST_ADDR:
          if (byte_done) begin
            cnt_d = 4'd0;
            if (addr_hit) begin
              oe_d   = 1'b1;
              busy_d = 1'b1;
            end
          end
        ST_ADDR_ACK, ST_RDATA_ACK: begin
          cnt_d = 4'd0;
          if (state_q == ST_RDATA_ACK || sh_q[0]) begin
            sh_d = reg_rd_data;
            oe_d = ~reg_rd_data[7];
          end else begin
            oe_d = 1'b0;
          end
        end
        ST_REG:
          if (byte_done) begin
            ptr_d = sh_q[REG_AW-1:0];
            oe_d  = 1'b1;
            cnt_d = 4'd0;
          end
        ST_WDATA:
          if (byte_done) begin
            wen_d = 1'b1;
            wa_d  = ptr_q;
            wd_d  = sh_q;
            inc_d = 1'b1;
            oe_d  = 1'b1;
            cnt_d = 4'd0;
          end
        ST_REG_ACK, ST_WDATA_ACK: oe_d = 1'b0;
        ST_RDATA:
          if (byte_done) begin
            oe_d = 1'b0;
          end else begin
            oe_d = ~sh_q[6];
            sh_d = {sh_q[6:0], 1'b0};
          end
        default: ;
      endcase
    end
  end

  // datapath registers; async reset releases SDA immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= 4'd0;
      sh_q        <= 8'd0;
      ptr_q       <= '0;
      inc_q       <= 1'b0;
      sda_oe      <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= 8'd0;
      busy        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      ptr_q       <= ptr_d;
      inc_q       <= inc_d;
      sda_oe      <= oe_d;
      reg_wr_en   <= wen_d;
      reg_wr_addr <= wa_d;
      reg_wr_data <= wd_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: doc/i2c_reg_target.md
Name: i2c_reg_target

Overview:
I2C target (slave) front end that sits directly upstream of the LED PWM core. It decodes I2C traffic from the open-drain SCL/SDA pins into single-cycle register-write strobes, and serves register reads back to the bus controller. It owns only the bus protocol. The register file and PWM logic sit downstream and consume reg_wr_* and supply reg_rd_data.

Parameters:
DEV_ADDR, 7'h2A, 7-bit I2C target address matched in the address byte.
REG_AW, 3, register pointer width; number of registers = 2**REG_AW.

Ports:
clk  in  1  system clock; must run at least 16x the SCL rate.
rst  in  1  asynchronous, active-high reset.
scl_in  in  1  raw SCL pin level; asynchronous to clk.
sda_in  in  1  raw SDA pin level; asynchronous to clk.
sda_oe  out  1  1 = pull SDA low; 0 = release SDA (pad output value is tied 0).
reg_wr_en  out  1  one-cycle write strobe.
reg_wr_addr  out  REG_AW  write register index.
reg_wr_data  out  8  write data.
reg_rd_addr  out  REG_AW  current pointer, for read data lookup.
reg_rd_data  in  8  combinational read data for reg_rd_addr.
busy  out  1  high from an addressed START until STOP.

Behaviour:
- Reset (async assert, sync release):
  - sda_oe=0, reg_wr_en=0, reg_wr_addr=0, reg_wr_data=0, pointer/reg_rd_addr=0, busy=0, state=IDLE.
  - Synchronizer flops reset to 1 (bus idle). No spurious START may be detected after reset.
- Input conditioning:
  - scl_in and sda_in each pass through a 2-flop synchronizer plus one history flop.
  - SCL rise/fall are detected from the synchronized and history levels.
- Bus conditions:
  - START: SDA falls while SCL high. STOP: SDA rises while SCL high.
  - Both are detected in every state and take priority over bit handling.
- Bit handling: SDA is sampled on SCL rise. sda_oe changes only on the clk cycle after an SCL fall.
- State machine (bit counter 0..7; MSB first):
  - IDLE: wait for START, then go to ADDR.
  - ADDR: shift 8 bits.
    - If addr[7:1]==DEV_ADDR: set busy, drive ACK, go to ADDR_ACK.
    - Otherwise: no ACK, go to WAIT_STOP.
  - ADDR_ACK: release SDA on the next SCL fall.
    - R/W=0: go to REG.
    - R/W=1: go to RDATA; the first bit is driven at that fall.
  - REG: shift 8 bits. Low REG_AW bits load the pointer; upper bits are ignored. ACK, then go to WDATA.
  - WDATA: shift 8 bits. On the SCL fall that starts the ACK slot:
    - reg_wr_en=1 for exactly one clk, with reg_wr_addr=pointer and reg_wr_data=byte.
    - pointer increments one clk later, wrapping 2**REG_AW-1 -> 0.
    - ACK, then stay in WDATA for the next byte.
  - RDATA: output the byte latched from reg_rd_data at the SCL fall that begins the byte.
    - Drive sda_oe = ~bit.
    - After 8 bits, release SDA and sample the controller ACK on SCL rise.
    - ACK (0): pointer increments (wrap), next byte.
    - NACK (1): go to WAIT_STOP.
  - WAIT_STOP: SDA released; wait for STOP or START.
- Repeated START in any state:
  - Release SDA, clear the bit counter, go to ADDR.
  - pointer is kept, so a write-pointer-then-read sequence works.
- STOP in any state: release SDA, clear busy, go to IDLE. A partial byte is discarded with no strobe.
- Mid-transfer reset: outputs return to reset values immediately. SDA must be released within the same cycle as rst assertion.
- No clock stretching, no general call, no 10-bit addressing.

Test Plan:
- Reset: assert rst with SCL=SDA=1 -> sda_oe=0, busy=0, no reg_wr_en for 100 clk after release.
- Write: START, 0x54, 0x03, 0xA5, STOP -> ACK on all three bytes; one reg_wr_en pulse with addr=3, data=0xA5; busy low after STOP.
- Burst wrap (REG_AW=3): write 0x11, 0x22, 0x33 starting at reg 7 -> strobes (7,0x11), (0,0x22), (1,0x33).
- Address mismatch: START, 0x56, then 0x03 -> SDA never pulled low, no strobe, busy stays 0.
- Read: START, 0x54, 0x02, rSTART, 0x55, model returns 0x3C/0xC3 for regs 2/3, controller ACK then NACK, STOP -> bus carries 0x3C then 0xC3; nothing is driven after the NACK.
- Abort: STOP after 4 data bits, then rst asserted mid-ACK in a second transfer -> no strobe from the partial byte; sda_oe falls to 0 the same cycle rst rises.
